// File: rtl/sum_fp_pkg.sv
// Shared definitions for the fixed-point sum pipeline: mode encoding and
// helpers that derive the full-precision format from the operand formats.
package sum_fp_pkg;

    localparam logic [1:0] MODE_TRUNC_WRAP = 2'b00;
    localparam logic [1:0] MODE_TRUNC_SAT  = 2'b01;
    localparam logic [1:0] MODE_ROUND_SAT  = 2'b10;
    localparam logic [1:0] MODE_ROUND_WRAP = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One extra integer bit so the aligned sum can never overflow.
    function automatic int full_width(input int nb_a, input int nbf_a,
                                      input int nb_b, input int nbf_b);
        return max_int(nb_a - nbf_a, nb_b - nbf_b) + 1 + max_int(nbf_a, nbf_b);
    endfunction

    function automatic logic mode_is_round(input logic [1:0] mode);
        return (mode == MODE_ROUND_SAT) || (mode == MODE_ROUND_WRAP);
    endfunction

    function automatic logic mode_is_sat(input logic [1:0] mode);
        return (mode == MODE_TRUNC_SAT) || (mode == MODE_ROUND_SAT);
    endfunction

endpackage

// File: rtl/fp_quant.sv
// Combinational re-quantiser: signed S(NB_IN,NBF_IN) to S(NB_O,NBF_O) with
// truncate/round and wrap/saturate selected by the mode input.
module fp_quant
    import sum_fp_pkg::*;
#(
    parameter int NB_IN  = 17,
    parameter int NBF_IN = 14,
    parameter int NB_O   = 11,
    parameter int NBF_O  = 10
) (
    input  logic [NB_IN-1:0] value,
    input  logic [1:0]       mode,
    output logic [NB_O-1:0]  result,
    output logic             ovf
);

    localparam int D      = NBF_IN - NBF_O;
    localparam int NBW    = NB_IN + 1;
    localparam int NBX    = max_int(NBW, NB_O) + 1;
    localparam int HALF_I = (D > 0) ? (1 << ((D > 0) ? D - 1 : 0)) : 0;

    localparam logic signed [NBW-1:0] HALF  = NBW'(HALF_I);
    localparam logic signed [NBX-1:0] O_MAX = {{(NBX-NB_O+1){1'b0}}, {(NB_O-1){1'b1}}};
    localparam logic signed [NBX-1:0] O_MIN = {{(NBX-NB_O+1){1'b1}}, {(NB_O-1){1'b0}}};

    logic signed [NBW-1:0] ext;
    logic signed [NBW-1:0] biased;
    logic signed [NBW-1:0] shifted;
    logic signed [NBX-1:0] quant;

    always_comb begin
        // The extra MSB keeps the rounding offset from wrapping at the top of range.
        ext     = {value[NB_IN-1], value};
        biased  = mode_is_round(mode) ? (ext + HALF) : ext;
        shifted = biased >>> D;
        quant   = {{(NBX-NBW){shifted[NBW-1]}}, shifted};
        ovf     = (quant > O_MAX) || (quant < O_MIN);
        if (ovf && mode_is_sat(mode)) begin
            result = (quant > O_MAX) ? O_MAX[NB_O-1:0] : O_MIN[NB_O-1:0];
        end else begin
            result = quant[NB_O-1:0];
        end
    end

endmodule

// File: rtl/sum_fp_pipe.sv
// Two-stage signed fixed-point adder with runtime quantisation/overflow mode,
// global-stall valid/ready handshake and overflow monitoring.
module sum_fp_pipe
    import sum_fp_pkg::*;
#(
    parameter int NB_A   = 16,
    parameter int NBF_A  = 14,
    parameter int NB_B   = 12,
    parameter int NBF_B  = 10,
    parameter int NB_O   = 11,
    parameter int NBF_O  = 10,
    parameter int NB_CNT = 8
) (
    input  logic                                              i_clock,
    input  logic                                              i_reset,
    input  logic                                              i_valid,
    output logic                                              o_ready,
    input  logic [NB_A-1:0]                                   i_A,
    input  logic [NB_B-1:0]                                   i_B,
    input  logic [1:0]                                        i_mode,
    output logic                                              o_valid,
    input  logic                                              i_ready,
    output logic [full_width(NB_A, NBF_A, NB_B, NBF_B)-1:0]   o_full,
    output logic [NB_O-1:0]                                   o_res,
    output logic                                              o_ovf,
    output logic                                              o_ovf_sticky,
    output logic [NB_CNT-1:0]                                 o_ovf_cnt,
    input  logic                                              i_clr_ovf
);

    localparam int NBF    = max_int(NBF_A, NBF_B);
    localparam int NBFULL = full_width(NB_A, NBF_A, NB_B, NBF_B);
    localparam int SH_A   = NBF - NBF_A;
    localparam int SH_B   = NBF - NBF_B;

    if (NBF_O > NBF) begin : g_fmt_check
        $error("NBF_O (%0d) exceeds the full-precision fractional bits (%0d)", NBF_O, NBF);
    end

    logic                     stall;
    logic                     take_in;
    logic                     ovf_event;
    logic signed [NBFULL-1:0] a_aligned;
    logic signed [NBFULL-1:0] b_aligned;
    logic [NB_O-1:0]          q_res;
    logic                     q_ovf;

    logic                     v1_reg;
    logic [NBFULL-1:0]        sum1_reg;
    logic [1:0]               mode1_reg;
    logic                     v2_reg;
    logic [NBFULL-1:0]        full2_reg;
    logic [NB_O-1:0]          res2_reg;
    logic                     ovf2_reg;
    logic                     sticky_reg;
    logic [NB_CNT-1:0]        cnt_reg;

    // A held output freezes the whole pipe, so both stages share one enable.
    assign stall     = v2_reg & ~i_ready;
    assign o_ready   = ~stall;
    assign take_in   = i_valid & ~stall;
    assign ovf_event = ~stall & v1_reg & q_ovf;

    assign a_aligned = NBFULL'($signed(i_A)) <<< SH_A;
    assign b_aligned = NBFULL'($signed(i_B)) <<< SH_B;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            v1_reg    <= 1'b0;
            sum1_reg  <= '0;
            mode1_reg <= '0;
        end else if (!stall) begin
            v1_reg <= take_in;
            if (take_in) begin
                sum1_reg  <= a_aligned + b_aligned;
                mode1_reg <= i_mode;
            end
        end
    end

    fp_quant #(
        .NB_IN  (NBFULL),
        .NBF_IN (NBF),
        .NB_O   (NB_O),
        .NBF_O  (NBF_O)
    ) u_quant (
        .value  (sum1_reg),
        .mode   (mode1_reg),
        .result (q_res),
        .ovf    (q_ovf)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            v2_reg    <= 1'b0;
            full2_reg <= '0;
            res2_reg  <= '0;
            ovf2_reg  <= 1'b0;
        end else if (!stall) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                full2_reg <= sum1_reg;
                res2_reg  <= q_res;
                ovf2_reg  <= q_ovf;
            end
        end
    end

    // Events are counted once per stage-2 load; a coincident clear drops the event.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr_ovf) begin
            sticky_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (ovf_event) begin
            sticky_reg <= 1'b1;
            if (cnt_reg != {NB_CNT{1'b1}}) begin
                cnt_reg <= cnt_reg + NB_CNT'(1);
            end
        end
    end

    assign o_valid      = v2_reg;
    assign o_full       = full2_reg;
    assign o_res        = res2_reg;
    assign o_ovf        = ovf2_reg;
    assign o_ovf_sticky = sticky_reg;
    assign o_ovf_cnt    = cnt_reg;

endmodule

// File: tb/tb_sum_fp_pipe.sv
// Randomised and directed bench for sum_fp_pipe against an arithmetic
// reference model with a transaction scoreboard.
module tb_sum_fp_pipe;

    localparam int NB_A   = 16;
    localparam int NBF_A  = 14;
    localparam int NB_B   = 12;
    localparam int NBF_B  = 10;
    localparam int NB_O   = 11;
    localparam int NBF_O  = 10;
    localparam int NB_CNT = 2;
    localparam int NBF    = (NBF_A > NBF_B) ? NBF_A : NBF_B;
    localparam int NBI    = (((NB_A-NBF_A) > (NB_B-NBF_B)) ? (NB_A-NBF_A) : (NB_B-NBF_B)) + 1;
    localparam int NBFULL = NBI + NBF;
    localparam int D      = NBF - NBF_O;

    logic              clk;
    logic              i_reset;
    logic              i_valid;
    logic              o_ready;
    logic [NB_A-1:0]   i_A;
    logic [NB_B-1:0]   i_B;
    logic [1:0]        i_mode;
    logic              o_valid;
    logic              i_ready;
    logic [NBFULL-1:0] o_full;
    logic [NB_O-1:0]   o_res;
    logic              o_ovf;
    logic              o_ovf_sticky;
    logic [NB_CNT-1:0] o_ovf_cnt;
    logic              i_clr_ovf;

    sum_fp_pipe #(
        .NB_A(NB_A), .NBF_A(NBF_A), .NB_B(NB_B), .NBF_B(NBF_B),
        .NB_O(NB_O), .NBF_O(NBF_O), .NB_CNT(NB_CNT)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_A          (i_A),
        .i_B          (i_B),
        .i_mode       (i_mode),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_full       (o_full),
        .o_res        (o_res),
        .o_ovf        (o_ovf),
        .o_ovf_sticky (o_ovf_sticky),
        .o_ovf_cnt    (o_ovf_cnt),
        .i_clr_ovf    (i_clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint full;
        longint res;
        bit     ovf;
        int     rdy;
        bit     seen;
    } item_t;

    typedef struct {
        int         a;
        int         b;
        logic [1:0] m;
        longint     full;
        longint     res;
        bit         ovf;
    } dvec_t;

    item_t  sb[$];
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_in = 0;
    int     n_out = 0;
    int     m_cnt = 0;
    bit     m_sticky = 1'b0;
    bit     chk_on = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint floor_div(input longint x, input longint d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic longint wrap_mod(input longint x, input int bits);
        longint m;
        m = longint'(1) << bits;
        return ((x % m) + m) % m;
    endfunction

    // Real-valued rules in integer form: align, add, scale by 2^-D with floor,
    // optional half-LSB bias, then clamp or wrap into the output range.
    function automatic item_t model(input longint a, input longint b, input logic [1:0] m);
        item_t  it;
        longint full, x, q, r, lim, hi, lo, scale;
        bit     rnd, sat;
        rnd   = (m == 2'b10) || (m == 2'b11);
        sat   = (m == 2'b01) || (m == 2'b10);
        full  = a * (longint'(1) << (NBF - NBF_A)) + b * (longint'(1) << (NBF - NBF_B));
        scale = longint'(1) << D;
        x     = full + ((rnd && D > 0) ? scale / 2 : 0);
        q     = floor_div(x, scale);
        lim   = longint'(1) << (NB_O - 1);
        hi    = lim - 1;
        lo    = -lim;
        it.ovf = (q > hi) || (q < lo);
        r = q;
        if (it.ovf && sat) r = (q > hi) ? hi : lo;
        it.res  = wrap_mod(r, NB_O);
        it.full = wrap_mod(full, NBFULL);
        it.rdy  = 0;
        it.seen = 1'b0;
        return it;
    endfunction

    task automatic tick();
        bit    ev, er;
        item_t it;
        #1;
        ev = (sb.size() > 0) && (sb[0].rdy <= cyc);
        er = !(ev && !i_ready);
        if (chk_on) begin
            chk("o_valid", o_valid, ev);
            chk("o_ready", o_ready, er);
            chk("ovf_cnt", o_ovf_cnt, m_cnt);
            chk("ovf_sticky", o_ovf_sticky, m_sticky);
            if (ev) begin
                chk("o_full", o_full, sb[0].full);
                chk("o_res", o_res, sb[0].res);
                chk("o_ovf", o_ovf, sb[0].ovf);
            end
        end
        @(posedge clk);
        cyc++;
        if (i_reset) begin
            sb.delete();
            m_cnt    = 0;
            m_sticky = 1'b0;
        end else begin
            if (ev && i_ready) begin
                $display("out #%0d full=%0d res=0x%0h ovf=%0b cycle=%0d",
                         n_out, sb[0].full, sb[0].res, sb[0].ovf, cyc);
                void'(sb.pop_front());
                n_out++;
            end
            if (i_valid && er) begin
                it     = model(longint'($signed(i_A)), longint'($signed(i_B)), i_mode);
                it.rdy = cyc + 1;
                sb.push_back(it);
                n_in++;
            end
            if (sb.size() > 0 && sb[0].rdy <= cyc && !sb[0].seen) begin
                it = sb.pop_front();
                if (!i_clr_ovf && it.ovf) begin
                    m_sticky = 1'b1;
                    if (m_cnt < (1 << NB_CNT) - 1) m_cnt++;
                end
                it.seen = 1'b1;
                sb.push_front(it);
            end
            if (i_clr_ovf) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end
        end
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        #1;
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_full"}, o_full, 0);
        chk({tag, "_res"}, o_res, 0);
        chk({tag, "_ovf"}, o_ovf, 0);
        chk({tag, "_sticky"}, o_ovf_sticky, 0);
        chk({tag, "_cnt"}, o_ovf_cnt, 0);
    endtask

    task automatic rand_operands();
        case ($urandom_range(0, 7))
            0: i_A = 16'h8000;
            1: i_A = 16'h7FFF;
            2: i_A = NB_A'($urandom_range(0, 31)) - NB_A'(16);
            default: i_A = NB_A'($urandom);
        endcase
        case ($urandom_range(0, 7))
            0: i_B = 12'h800;
            1: i_B = 12'h7FF;
            default: i_B = NB_B'($urandom);
        endcase
    endtask

    dvec_t dv[10] = '{
        '{28672,   512, 2'b01, 36864,     'h3FF, 1'b1},
        '{28672,   512, 2'b00, 36864,     'h100, 1'b1},
        '{8,       0,   2'b00, 8,         0,     1'b0},
        '{8,       0,   2'b10, 8,         1,     1'b0},
        '{7,       0,   2'b10, 7,         0,     1'b0},
        '{-8,      0,   2'b00, 131064,    'h7FF, 1'b0},
        '{-8,      0,   2'b10, 131064,    0,     1'b0},
        '{-32768, -2048, 2'b01, 'h10000,  'h400, 1'b1},
        '{-32768, -2048, 2'b00, 'h10000,  0,     1'b1},
        '{28672,   520, 2'b11, 36992,     'h108, 1'b1}
    };

    initial begin
        int n0_in, n0_out, prev_in, stall_left;
        i_reset = 1'b1; i_valid = 1'b0; i_A = '0; i_B = '0; i_mode = 2'b00;
        i_ready = 1'b1; i_clr_ovf = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_state("rst_init");

        // Directed vectors, one at a time with an open output.
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1;
            i_A     = NB_A'(dv[k].a);
            i_B     = NB_B'(dv[k].b);
            i_mode  = dv[k].m;
            tick();
            i_valid = 1'b0;
            tick();
            #1;
            chk($sformatf("dir%0d_valid", k), o_valid, 1);
            chk($sformatf("dir%0d_full", k), o_full, dv[k].full);
            chk($sformatf("dir%0d_res", k), o_res, dv[k].res);
            chk($sformatf("dir%0d_ovf", k), o_ovf, dv[k].ovf);
            if (k == 0) chk("dir0_cnt", o_ovf_cnt, 1);
        end
        tick();
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;

        // Counter saturation, then a clear coincident with an overflow load.
        i_A = NB_A'(28672); i_B = NB_B'(512); i_mode = 2'b01;
        i_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #1;
        chk("cnt_sat", o_ovf_cnt, 3);
        chk("sticky_set", o_ovf_sticky, 1);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        #1;
        chk("clr_win_valid", o_valid, 1);
        chk("clr_win_ovf", o_ovf, 1);
        chk("clr_win_cnt", o_ovf_cnt, 0);
        chk("clr_win_sticky", o_ovf_sticky, 0);
        tick();
        tick();

        // Back-pressure: six samples, output stalled 3 cycles after the 2nd.
        n0_in = n_in; n0_out = n_out; prev_in = n_in; stall_left = 3;
        rand_operands();
        i_mode = 2'($urandom_range(0, 3));
        for (int c = 0; c < 60 && (n_out - n0_out) < 6; c++) begin
            i_valid = (n_in - n0_in) < 6;
            if ((n_out - n0_out) == 2 && stall_left > 0) begin
                i_ready = 1'b0;
                stall_left--;
            end else begin
                i_ready = 1'b1;
            end
            tick();
            if (n_in != prev_in) begin
                prev_in = n_in;
                rand_operands();
                i_mode = 2'($urandom_range(0, 3));
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("bp_accepted", n_in - n0_in, 6);
        chk("bp_delivered", n_out - n0_out, 6);
        chk("bp_stall_done", stall_left, 0);

        // Random traffic with random back-pressure and occasional clears.
        for (int c = 0; c < 400; c++) begin
            rand_operands();
            i_mode    = 2'($urandom_range(0, 3));
            i_valid   = ($urandom_range(0, 9) < 7);
            i_ready   = ($urandom_range(0, 3) != 0);
            i_clr_ovf = ($urandom_range(0, 49) == 0);
            tick();
        end
        i_valid = 1'b0; i_ready = 1'b1; i_clr_ovf = 1'b0;
        for (int c = 0; c < 4; c++) tick();

        // Reset with two overflowing samples in flight.
        i_A = NB_A'(-32768); i_B = NB_B'(-2048); i_mode = 2'b01;
        i_valid = 1'b1;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_valid = 1'b0;
        check_reset_state("rst_flush");
        for (int c = 0; c < 5; c++) tick();
        chk("rst_no_stale", o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before %0d", 200000);
        $fatal(1, "watchdog");
    end

endmodule
